// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter that shares one synchronous FIFO write port among
// NUM_REQ valid/ready producers. A producer keeps the port for a burst of up
// to BURST_MAX writes. The grant is released early if the owner drops valid.
// The arbiter stalls without releasing the grant while the FIFO is full.
//
// Ports
//   clk_i           clock, all state on posedge
//   rst_i           synchronous active-high reset
//   req_valid_i     per-producer valid
//   req_data_i      producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o     per-producer ready (word taken when valid & ready)
//   fifo_full_i     FIFO full flag, used in the same cycle as the write
//   fifo_w_en_o     FIFO write enable
//   fifo_data_in_o  FIFO write data (owner's word while granted, else 0)
//   grant_valid_o   a producer currently owns the port
//   grant_id_o      index of the current owner
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_w_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_in_o,
    output logic                          grant_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(BURST_MAX + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    burst_cnt_q, burst_cnt_d;

    logic [DATA_WIDTH-1:0] words_s [NUM_REQ];
    logic [NUM_REQ-1:0]    owner_dec_s;
    logic [IDW-1:0]        next_ptr_s;
    logic [IDW:0]          idx_s;
    logic                  win_found_s;
    logic [IDW-1:0]        win_id_s;
    logic                  transfer_s;

    // Split the flat data bus into one word per producer.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words_s[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign owner_dec_s = NUM_REQ'(1) << owner_q;
    assign next_ptr_s  = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + IDW'(1);

    // Round-robin search: scan offsets from rr_ptr upward, first valid wins.
    // idx_s is one bit wider so rr_ptr+offset can be folded back modulo NUM_REQ.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        idx_s       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s       = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            idx_s       = (idx_s >= (IDW+1)'(NUM_REQ)) ? idx_s - (IDW+1)'(NUM_REQ) : idx_s;
            win_id_s    = (req_valid_i[idx_s[IDW-1:0]] && !win_found_s) ? idx_s[IDW-1:0] : win_id_s;
            win_found_s = win_found_s | req_valid_i[idx_s[IDW-1:0]];
        end
    end

    // Combinational handshake toward producers and FIFO; suppressed in reset
    // so no partial write leaks out during the reset cycle.
    always_comb begin
        transfer_s     = 1'b0;
        req_ready_o    = '0;
        fifo_w_en_o    = 1'b0;
        fifo_data_in_o = '0;
        if (!rst_i && (state_q == GRANT)) begin
            req_ready_o    = fifo_full_i ? '0 : owner_dec_s;
            transfer_s     = req_valid_i[owner_q] & ~fifo_full_i;
            fifo_w_en_o    = transfer_s;
            fifo_data_in_o = words_s[owner_q];
        end else begin
            transfer_s     = 1'b0;
            req_ready_o    = '0;
        end
    end

    // Next-state logic for grant ownership, burst length and fairness pointer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found_s) begin
                    state_d     = GRANT;
                    owner_d     = win_id_s;
                    burst_cnt_d = '0;
                end else begin
                    state_d     = IDLE;
                end
            end
            GRANT: begin
                if (transfer_s) begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                    if (burst_cnt_q == CW'(BURST_MAX - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr_s;
                    end else begin
                        state_d  = GRANT;
                    end
                end else if (!req_valid_i[owner_q]) begin
                    // Owner ran dry: give the port away early.
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr_s;
                end else begin
                    // FIFO full with a pending word: hold the grant.
                    state_d  = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign grant_valid_o = (state_q == GRANT);
    assign grant_id_o    = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// BURST_MAX=4). A behavioural model of the arbitration rules predicts every
// output each cycle; a table of hand-computed vectors, directed corner-case
// sequences and a random phase drive the design.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BM = 4;

    logic              clk;
    logic              rst_i;
    logic [NR-1:0]     req_valid_i;
    logic [NR*DW-1:0]  req_data_i;
    logic [NR-1:0]     req_ready_o;
    logic              fifo_full_i;
    logic              fifo_w_en_o;
    logic [DW-1:0]     fifo_data_in_o;
    logic              grant_valid_o;
    logic [1:0]        grant_id_o;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .fifo_full_i    (fifo_full_i),
        .fifo_w_en_o    (fifo_w_en_o),
        .fifo_data_in_o (fifo_data_in_o),
        .grant_valid_o  (grant_valid_o),
        .grant_id_o     (grant_id_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model: who holds the port, where the next search starts,
    // and how many words the current holder has written.
    bit m_known = 0;
    bit m_gnt   = 0;
    int m_own   = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] dut_q[$];
    int            grant_q[$];
    int            wr_q[$];
    logic          prev_gv = 1'b0;
    int            pc[NR];

    logic          o_gv;
    logic [1:0]    o_gid;
    logic [NR-1:0] o_rdy;
    logic          o_wen;
    logic [DW-1:0] o_dat;

    typedef struct {
        logic          rst;
        logic [NR-1:0] v;
        logic [DW-1:0] d2;
        logic          f;
        logic          gv;
        logic [1:0]    gid;
        logic [NR-1:0] rdy;
        logic          wen;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] mkd();
        logic [NR*DW-1:0] d;
        d = '0;
        for (int i = 0; i < NR; i++) d[i*DW +: DW] = DW'((i << 4) | (pc[i] & 15));
        return d;
    endfunction

    // One clock cycle: drive at negedge, compare just before posedge,
    // then advance the model across the edge.
    task automatic step(input logic r, input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input logic f);
        logic          e_gv;
        logic [1:0]    e_gid;
        logic [NR-1:0] e_rdy;
        logic          e_wen;
        logic [DW-1:0] e_dat;
        bit            found;
        int            w;
        @(negedge clk);
        rst_i = r; req_valid_i = v; req_data_i = d; fifo_full_i = f;
        #4;
        o_gv = grant_valid_o; o_gid = grant_id_o; o_rdy = req_ready_o;
        o_wen = fifo_w_en_o; o_dat = fifo_data_in_o;
        if (o_wen === 1'b1) dut_q.push_back(o_dat);
        if (o_gv === 1'b1 && prev_gv !== 1'b1) begin
            grant_q.push_back(int'(o_gid));
            wr_q.push_back(0);
        end
        if (o_wen === 1'b1 && wr_q.size() > 0) wr_q[wr_q.size()-1] = wr_q[wr_q.size()-1] + 1;
        prev_gv = o_gv;

        e_gv = m_gnt; e_gid = 2'(m_own); e_rdy = '0; e_wen = 1'b0; e_dat = '0;
        if (!r && m_gnt) begin
            e_rdy = f ? '0 : (NR'(1) << m_own);
            e_wen = v[m_own] && !f;
            e_dat = d[m_own*DW +: DW];
        end
        if (m_known) begin
            chk("grant_valid", 32'(o_gv), 32'(e_gv));
            chk("grant_id", 32'(o_gid), 32'(e_gid));
            chk("req_ready", 32'(o_rdy), 32'(e_rdy));
            chk("fifo_w_en", 32'(o_wen), 32'(e_wen));
            chk("fifo_data_in", 32'(o_dat), 32'(e_dat));
        end

        @(posedge clk);
        cyc++;
        if (r) begin
            m_gnt = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_known = 1;
        end else if (!m_gnt) begin
            found = 0;
            for (int k = 0; k < NR; k++) begin
                w = (m_ptr + k) % NR;
                if (!found && v[w]) begin
                    found = 1; m_gnt = 1; m_own = w; m_cnt = 0;
                end
            end
        end else if (v[m_own] && !f) begin
            exp_q.push_back(d[m_own*DW +: DW]);
            m_cnt++;
            if (m_cnt == BM) begin
                m_gnt = 0; m_ptr = (m_own + 1) % NR;
            end
        end else if (!v[m_own]) begin
            m_gnt = 0; m_ptr = (m_own + 1) % NR;
        end
    endtask

    task automatic clear_log();
        grant_q.delete();
        wr_q.delete();
        for (int i = 0; i < NR; i++) pc[i] = 0;
    endtask

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int gv_cnt;
        int p1_left;
        logic [NR-1:0] v;
        logic          rm_r[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [NR-1:0] rm_v[7] = '{4'h2, 4'h4, 4'h4, 4'h4, 4'hF, 4'hF, 4'hF};

        rst_i = 1'b1; req_valid_i = '0; req_data_i = '0; fifo_full_i = 1'b0;

        // Reset + single-producer vectors (p0=11, p1=22, p2=table, p3=33).
        vecs[0]  = '{1'b1, 4'hF, 8'hA0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 4'hF, 8'hA0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 4'hF, 8'hA0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 4'h4, 8'hA0, 1'b0, 1'b1, 2'd0, 4'h1, 1'b0, 8'h11};
        vecs[4]  = '{1'b0, 4'h4, 8'hA0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 4'h4, 8'hA0, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1, 8'hA0};
        vecs[6]  = '{1'b0, 4'h4, 8'hA1, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1, 8'hA1};
        vecs[7]  = '{1'b0, 4'h4, 8'hA2, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1, 8'hA2};
        vecs[8]  = '{1'b0, 4'h4, 8'hA3, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1, 8'hA3};
        vecs[9]  = '{1'b0, 4'h4, 8'hA4, 1'b0, 1'b0, 2'd2, 4'h0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 4'h4, 8'hA4, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1, 8'hA4};
        vecs[11] = '{1'b0, 4'h4, 8'hA5, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1, 8'hA5};
        vecs[12] = '{1'b0, 4'h0, 8'hA6, 1'b0, 1'b1, 2'd2, 4'h4, 1'b0, 8'hA6};
        vecs[13] = '{1'b0, 4'h0, 8'hA6, 1'b0, 1'b0, 2'd2, 4'h0, 1'b0, 8'h00};

        step(1'b1, 4'hF, 32'h0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rst, vecs[i].v, {8'h33, vecs[i].d2, 8'h22, 8'h11}, vecs[i].f);
            chk($sformatf("vec%0d_gv", i), 32'(o_gv), 32'(vecs[i].gv));
            chk($sformatf("vec%0d_gid", i), 32'(o_gid), 32'(vecs[i].gid));
            chk($sformatf("vec%0d_ready", i), 32'(o_rdy), 32'(vecs[i].rdy));
            chk($sformatf("vec%0d_wen", i), 32'(o_wen), 32'(vecs[i].wen));
            chk($sformatf("vec%0d_data", i), 32'(o_dat), 32'(vecs[i].dout));
        end

        // Round-robin fairness with all producers continuously valid.
        step(1'b1, 4'h0, 32'h0, 1'b0);
        clear_log();
        gv_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            step(1'b0, 4'hF, mkd(), 1'b0);
            for (int i = 0; i < NR; i++) if (o_rdy[i] === 1'b1) pc[i]++;
            if (o_gv === 1'b1) gv_cnt++;
        end
        chk("rr_grant_count", 32'(grant_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_order%0d", i), (grant_q.size() > i) ? grant_q[i] : -1, exp_order[i]);
            chk($sformatf("rr_burst%0d", i), (wr_q.size() > i) ? wr_q[i] : -1, BM);
        end
        chk("rr_busy_cycles", 32'(gv_cnt), 32'd20);

        // Early release: rr_ptr is 1 here; p1 gives 2 words then stops.
        clear_log();
        p1_left = 2;
        for (int c = 0; c < 8; c++) begin
            v = {1'b1, 1'b0, (p1_left > 0), (p1_left == 0)};
            step(1'b0, v, mkd(), 1'b0);
            if (o_rdy[1] === 1'b1 && v[1]) p1_left--;
            for (int i = 0; i < NR; i++) if (o_rdy[i] === 1'b1) pc[i]++;
        end
        chk("er_first_owner", (grant_q.size() > 0) ? grant_q[0] : -1, 1);
        chk("er_first_words", (wr_q.size() > 0) ? wr_q[0] : -1, 2);
        chk("er_second_owner", (grant_q.size() > 1) ? grant_q[1] : -1, 3);

        // Full stall for 3 cycles after the second word of producer 0.
        step(1'b1, 4'h0, 32'h0, 1'b0);
        clear_log();
        for (int c = 0; c < 9; c++) begin
            step(1'b0, 4'h1, mkd(), (c >= 3 && c <= 5));
            if (o_rdy[0] === 1'b1) pc[0]++;
            if (c >= 3 && c <= 5) begin
                chk("stall_wen", 32'(o_wen), 32'd0);
                chk("stall_ready", 32'(o_rdy), 32'd0);
                chk("stall_hold", 32'({o_gv, o_gid}), 32'({1'b1, 2'd0}));
            end
            if (c == 6 || c == 7) chk("stall_resume", 32'({o_wen, o_gid}), 32'({1'b1, 2'd0}));
            if (c == 8) chk("stall_release", 32'(o_gv), 32'd0);
        end
        chk("stall_burst", (wr_q.size() > 0) ? wr_q[0] : -1, BM);

        // Reset mid-burst after moving rr_ptr away from 0.
        step(1'b1, 4'h0, 32'h0, 1'b0);
        clear_log();
        for (int c = 0; c < 7; c++) begin
            step(rm_r[c], rm_v[c], mkd(), 1'b0);
            for (int i = 0; i < NR; i++) if (o_rdy[i] === 1'b1) pc[i]++;
            if (c == 3) chk("rm_write_before", 32'({o_wen, o_gid}), 32'({1'b1, 2'd2}));
            if (c == 4) chk("rm_reset_cycle", 32'({o_wen, o_rdy}), 32'd0);
            if (c == 5) chk("rm_after_idle", 32'({o_gv, o_wen}), 32'd0);
            if (c == 6) chk("rm_regrant0", 32'({o_gv, o_gid}), 32'({1'b1, 2'd0}));
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 63) == 0), NR'($urandom), $urandom, ($urandom_range(0, 3) == 0));
        end

        // Scoreboard: written words in order equal the accepted words.
        chk("sb_count", 32'(dut_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++) begin
            chk($sformatf("sb_word%0d", i), 32'(dut_q[i]), 32'(exp_q[i]));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to BURST_MAX writes, and drives the FIFO write-enable and data from the granted producer. It sits directly in front of the team's syn_fifo write side and respects its full flag.

## Interface
- NUM_REQ, 4, number of producers (≥2)
- DATA_WIDTH, 8, word width; matches FIFO DATA_WIDTH
- BURST_MAX, 4, max consecutive writes per grant (≥1)

- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  producer i has a word
- req_data  in  NUM_REQ*DATA_WIDTH  producer i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  producer i word accepted this cycle when valid&ready
- fifo_full  in  1  FIFO full flag
- fifo_w_en  out  1  FIFO write enable
- fifo_data_in  out  DATA_WIDTH  FIFO write data
- grant_valid  out  1  a producer currently owns the port
- grant_id  out  $clog2(NUM_REQ)  index of current owner

## Operation
- FSM states: IDLE and GRANT. Registers: state, owner, rr_ptr, burst_cnt (width $clog2(BURST_MAX+1)).
- Reset (rst=1 at posedge) puts the block in this state:
  - state=IDLE, owner=0, rr_ptr=0, burst_cnt=0.
  - Outputs: grant_valid=0, grant_id=0, req_ready=0, fifo_w_en=0, fifo_data_in=0.
  - Reset overrides any in-progress burst. No partial write is issued in the reset cycle.
- IDLE:
  - Search req_valid starting at index rr_ptr, ascending, wrapping modulo NUM_REQ. The first asserted index wins.
  - If a winner exists: owner←winner, burst_cnt←0, state→GRANT.
  - If no winner: stay in IDLE.
  - In IDLE, req_ready=0 and fifo_w_en=0.
- GRANT:
  - req_ready[owner]=!fifo_full. All other req_ready bits are 0.
  - Transfer = req_valid[owner] & !fifo_full.
  - fifo_w_en=transfer, combinational in the same cycle.
  - fifo_data_in=req_data slice of owner, always driven while in GRANT. It is 0 in IDLE.
  - On a transfer: burst_cnt←burst_cnt+1.
  - If a transfer occurs and burst_cnt==BURST_MAX-1: state→IDLE, rr_ptr←(owner+1) mod NUM_REQ.
  - If req_valid[owner]=0: no transfer, state→IDLE, rr_ptr←(owner+1) mod NUM_REQ.
  - fifo_full=1 with req_valid[owner]=1: stall. Hold the grant with no transfer; burst_cnt and state are unchanged.
- grant_valid=(state==GRANT). grant_id=owner, a registered value.
- rr_ptr wrap: owner=NUM_REQ-1 → rr_ptr=0.
- Non-owner valids are ignored while in GRANT. The arbiter never drops a word: a word is consumed only on valid&ready.

## Timing
- Arbitration latency: a request seen in IDLE at edge N gives grant_valid=1 after edge N. The first write can occur in the cycle following edge N.
- Release costs one IDLE cycle. With continuous demand, throughput is BURST_MAX writes per BURST_MAX+1 cycles.
- A request arriving in the same cycle as a release is considered in the following IDLE cycle.
- req_ready and fifo_w_en are combinational from state, owner, req_valid and fifo_full. There is no register between the producer and the FIFO.
- fifo_full is sampled in the same cycle as the write. The FIFO must deassert full combinationally from its count.

## Test plan
- Reset: hold rst=1 for 2 cycles with all req_valid=1. Required: req_ready=0, fifo_w_en=0, grant_valid=0, grant_id=0 throughout. After release, producer 0 is granted first.
- Single producer: producer 2 holds valid with data 0xA0..0xA5. Required:
  - grant_id=2; writes 0xA0–0xA3 on 4 consecutive cycles.
  - One IDLE cycle follows, then a re-grant to 2 for 0xA4, 0xA5.
- Round-robin fairness: all 4 producers continuously valid (BURST_MAX=4). Required:
  - Grant order 0,1,2,3,0.
  - Each grant writes exactly 4 words, with one IDLE cycle between grants.
- Early release: producer 1 is valid for 2 words, then drops valid while producer 3 is valid. Required:
  - Producer 1 writes 2 words, then the grant releases.
  - The next grant goes to 3; rr_ptr was 2, so producer 0 is not granted.
- Full stall: fifo_full=1 for 3 cycles mid-burst after the second word. Required:
  - fifo_w_en=0 and req_ready=0 for those cycles; grant is held.
  - The remaining 2 words are written after full drops, with the same owner.
- Reset mid-burst: assert rst during GRANT after 1 write. Required: the next cycle has IDLE state, rr_ptr=0 and no fifo_w_en. Scoreboard data order matches accepted words only.
